// File: rtl/parity_pkg.sv
// Shared types for the serial running-parity checker.
package parity_pkg;

  typedef enum logic {
    EVEN = 1'b0,
    ODD  = 1'b1
  } parity_state_t;

  localparam parity_state_t RESET_STATE = EVEN;

endpackage

// File: rtl/parity_checker_if.sv
// Serial data bit in, parity flag out; bundles the stream side of the checker.
interface parity_checker_if;
  logic x;
  logic z;

  modport master (output x, input z);
  modport slave  (input x, output z);
endinterface

// File: rtl/parity_checker.sv
// Two-state Moore FSM tracking the parity of 1s seen on x since the last reset.
module parity_checker
  import parity_pkg::*;
#(
  parameter bit Z_INVERT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic x,
  output logic z
);

  parity_state_t state_reg;
  parity_state_t state_next;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      EVEN:    state_next = x ? ODD : EVEN;
      ODD:     state_next = x ? EVEN : ODD;
      default: state_next = RESET_STATE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= RESET_STATE;
    end else begin
      state_reg <= state_next;
    end
  end

  // z depends on the state register only, so x never reaches it combinationally.
  assign z = (state_reg == ODD) ^ Z_INVERT;

endmodule

// File: tb/tb_parity_checker.sv
// Randomized and directed bench for parity_checker, both output polarities side by side.
module tb_parity_checker;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  parity_checker_if bus0 ();
  parity_checker_if bus1 ();

  parity_checker #(.Z_INVERT(1'b0)) dut0 (
    .clk (clk),
    .rst (rst),
    .x   (bus0.x),
    .z   (bus0.z)
  );

  parity_checker #(.Z_INVERT(1'b1)) dut1 (
    .clk (clk),
    .rst (rst),
    .x   (bus1.x),
    .z   (bus1.z)
  );

  int checks   = 0;
  int failures = 0;
  int ones     = 0;  // number of 1s accepted since the last reset

  task automatic check_val(input string tag, input logic obs, input logic exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%b expected=%b", tag, obs, exp);
    end else begin
      $display("chk  %s z=%b", tag, obs);
    end
  endtask

  // Apply one bit (or a reset) for one edge, then compare both polarities with the model.
  task automatic step(input logic r, input logic b, input string tag);
    logic exp_odd;
    @(negedge clk);
    rst    = r;
    bus0.x = b;
    bus1.x = b;
    @(posedge clk);
    #1;
    if (r) ones = 0;
    else   ones = ones + int'(b);
    exp_odd = ((ones % 2) == 1);
    check_val({tag, "_n"}, bus0.z, exp_odd);
    check_val({tag, "_i"}, bus1.z, ~exp_odd);
  endtask

  logic mixed_x [13] = '{0,0,1,1,1,1,1,0,1,1,0,1,1};
  logic mixed_z [13] = '{0,0,1,0,1,0,1,1,0,1,1,0,1};

  initial begin
    bus0.x = 1'b1;
    bus1.x = 1'b1;

    // Reset held for two edges with x=1
    step(1'b1, 1'b1, "reset0");
    step(1'b1, 1'b1, "reset1");

    // Mixed stream, also checked against the literal expected table
    for (int i = 0; i < 13; i++) begin
      step(1'b0, mixed_x[i], $sformatf("mixed%0d", i));
      check_val($sformatf("mixed_tbl%0d", i), bus0.z, mixed_z[i]);
    end

    // Stability: x wiggles between edges, z must not move
    for (int i = 0; i < 4; i++) begin
      logic held0, held1, b;
      b = 1'($urandom_range(0, 1));
      step(1'b0, b, $sformatf("stab%0d", i));
      held0 = ((ones % 2) == 1);
      held1 = ~held0;
      #1 bus0.x = ~bus0.x; bus1.x = ~bus1.x;
      #1 bus0.x = ~bus0.x; bus1.x = ~bus1.x;
      #1 bus0.x = ~bus0.x; bus1.x = ~bus1.x;
      check_val($sformatf("stab_hold%0d_n", i), bus0.z, held0);
      check_val($sformatf("stab_hold%0d_i", i), bus1.z, held1);
    end

    // Mid-stream reset from ODD
    step(1'b1, 1'b0, "mid_pre_rst");
    step(1'b0, 1'b1, "mid_odd");
    check_val("mid_odd_tbl", bus0.z, 1'b1);
    step(1'b1, 1'b1, "mid_rst");
    check_val("mid_rst_tbl", bus0.z, 1'b0);
    step(1'b0, 1'b1, "mid_a");
    check_val("mid_a_tbl", bus0.z, 1'b1);
    step(1'b0, 1'b1, "mid_b");
    check_val("mid_b_tbl", bus0.z, 1'b0);

    // Inverted polarity sequence
    step(1'b1, 1'b1, "inv_rst");
    check_val("inv_rst_tbl", bus1.z, 1'b1);
    step(1'b0, 1'b1, "inv1");
    check_val("inv1_tbl", bus1.z, 1'b0);
    step(1'b0, 1'b0, "inv2");
    check_val("inv2_tbl", bus1.z, 1'b0);
    step(1'b0, 1'b1, "inv3");
    check_val("inv3_tbl", bus1.z, 1'b1);

    // Long run of ones then zeros
    step(1'b1, 1'b0, "long_rst");
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, $sformatf("long1_%0d", i));
      check_val($sformatf("long1_tbl%0d", i), bus0.z, (i % 2) == 0);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, $sformatf("long0_%0d", i));
      check_val($sformatf("long0_tbl%0d", i), bus0.z, 1'b0);
    end

    // Randomized stream with occasional resets
    for (int i = 0; i < 200; i++) begin
      step(($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
